// File: rtl/serial_add_arb_pkg.sv
// Shared definitions for the serial adder arbiter: the sequencer state
// encoding and the default abort threshold for the optional WAIT timeout.
package serial_add_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/serial_add_arb_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set request
// bit found searching ptr, ptr+1, ... with wrap from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_any,
    output logic [IW-1:0]   o_id
);

    logic [IW-1:0] w_idx;

    // Scan from farthest offset down so the closest-to-ptr request wins last.
    always_comb begin
        o_any = 1'b0;
        o_id  = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_idx]) begin
                o_any = 1'b1;
                o_id  = w_idx;
            end
        end
    end

endmodule

// File: rtl/serial_add_arb.sv
// serial_add_arb: round-robin sequencer sharing one bit-serial adder engine
// among NREQ requesters. Arbitrates only in IDLE, launches the engine with a
// one-cycle start, waits for done and returns the tagged sum.
// Optional WAIT abort counter enabled by SERIAL_ADD_ARB_TIMEOUT_EN.
module serial_add_arb
    import serial_add_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int IW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    output logic [NREQ-1:0]       o_gnt,
    output logic                  o_add_start,
    output logic [WIDTH-1:0]      o_add_a,
    output logic [WIDTH-1:0]      o_add_b,
    input  logic                  i_add_done,
    input  logic [WIDTH-1:0]      i_add_sum,
    output logic                  o_rsp_valid,
    output logic [IW-1:0]         o_rsp_id,
    output logic [WIDTH-1:0]      o_rsp_sum,
    output logic                  o_rsp_err,
    output logic                  o_busy
);

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_id;
    logic          w_any;
    logic [IW-1:0] w_id;
    logic [IW-1:0] w_ptr_nxt;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_id  (w_id)
    );

    // Next search starts just past the requester that was served.
    assign w_ptr_nxt = (r_id == IW'(NREQ - 1)) ? '0 : r_id + 1'b1;

`ifdef SERIAL_ADD_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Sequencer FSM with registered outputs; WAIT aborts after TIMEOUT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            o_gnt       <= '0;
            o_add_start <= 1'b0;
            o_add_a     <= '0;
            o_add_b     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_sum   <= '0;
            o_rsp_err   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_gnt       <= '0;
            o_add_start <= 1'b0;
            o_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id        <= w_id;
                        o_add_a     <= i_req_a[int'(w_id)*WIDTH +: WIDTH];
                        o_add_b     <= i_req_b[int'(w_id)*WIDTH +: WIDTH];
                        o_gnt       <= NREQ'(1) << w_id;
                        o_add_start <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_add_done) begin
                        o_rsp_sum   <= i_add_sum;
                        o_rsp_err   <= 1'b0;
                        o_rsp_id    <= r_id;
                        o_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        o_rsp_sum   <= '0;
                        o_rsp_err   <= 1'b1;
                        o_rsp_id    <= r_id;
                        o_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= w_ptr_nxt;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign o_rsp_err = 1'b0;

    // Sequencer FSM with registered outputs; WAIT holds until engine done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            o_gnt       <= '0;
            o_add_start <= 1'b0;
            o_add_a     <= '0;
            o_add_b     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_sum   <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_gnt       <= '0;
            o_add_start <= 1'b0;
            o_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id        <= w_id;
                        o_add_a     <= i_req_a[int'(w_id)*WIDTH +: WIDTH];
                        o_add_b     <= i_req_b[int'(w_id)*WIDTH +: WIDTH];
                        o_gnt       <= NREQ'(1) << w_id;
                        o_add_start <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_add_done) begin
                        o_rsp_sum   <= i_add_sum;
                        o_rsp_id    <= r_id;
                        o_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= w_ptr_nxt;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Bench for serial_add_arb: client and engine models drive the DUT, a
// transaction-level model predicts every output each cycle, and directed
// phases pin single request, rotation, wrap, reset and timeout behaviour.
`timescale 1ns/1ps
module tb_serial_add_arb;
    localparam int NREQ = 4, WIDTH = 8, TIMEOUT = 32, IW = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       i_req = '0;
    logic [NREQ*WIDTH-1:0] i_req_a = '0, i_req_b = '0;
    logic                  i_add_done = 1'b0;
    logic [WIDTH-1:0]      i_add_sum = '0;
    logic [NREQ-1:0]       o_gnt;
    logic                  o_add_start, o_rsp_valid, o_rsp_err, o_busy;
    logic [WIDTH-1:0]      o_add_a, o_add_b, o_rsp_sum;
    logic [IW-1:0]         o_rsp_id;

    always #5 clk = ~clk;

    serial_add_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_gnt(o_gnt), .o_add_start(o_add_start), .o_add_a(o_add_a), .o_add_b(o_add_b),
        .i_add_done(i_add_done), .i_add_sum(i_add_sum), .o_rsp_valid(o_rsp_valid),
        .o_rsp_id(o_rsp_id), .o_rsp_sum(o_rsp_sum), .o_rsp_err(o_rsp_err), .o_busy(o_busy));

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // client / engine state
    bit pend[NREQ], outst[NREQ], auto_rq[NREQ];
    logic [7:0] cl_a[NREQ], cl_b[NREQ];
    bit rand_mode = 0, eng_never = 0;
    int eng_dly = 9, eng_cnt = -1;
    logic [7:0] eng_sum = 0;

    // event log
    int gnt_log[$];
    int cyc = 0, start_cyc = 0, done_cyc = 0, rsp_cyc = 0, rsp_count = 0, last_id = 0;
    int req_cyc[NREQ], gnt_cyc[NREQ];
    logic [NREQ-1:0] last_gnt_vec = 0;
    logic [7:0] start_a = 0, start_b = 0, last_sum = 0;
    logic last_err = 0;

    // transaction-level model
    bit m_busy = 0, m_rsp = 0;
    int m_id = 0, m_ptr = 0, m_age = 0, win;
    logic [NREQ-1:0] e_gnt;
    logic e_start, e_rv, e_err = 0;
    logic [7:0] e_a = 0, e_b = 0, e_sum = 0;
    logic [IW-1:0] e_id = 0;

    always begin
        @(posedge clk); #1;
        cyc++;
        e_gnt = '0; e_start = 0; e_rv = 0;
        if (rst) begin
            m_busy = 0; m_rsp = 0; m_ptr = 0;
            e_a = 0; e_b = 0; e_sum = 0; e_id = 0; e_err = 0;
        end else if (!m_busy) begin
            win = -1;
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && i_req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            if (win >= 0) begin
                m_busy = 1; m_id = win; m_age = 0;
                e_gnt = NREQ'(1) << win; e_start = 1;
                e_a = i_req_a[win*WIDTH +: WIDTH];
                e_b = i_req_b[win*WIDTH +: WIDTH];
            end
        end else begin
            m_age++;
            if (m_rsp) begin
                m_rsp = 0; m_busy = 0; m_ptr = (m_id + 1) % NREQ;
            end else if (m_age >= 2 && i_add_done) begin
                e_rv = 1; e_id = IW'(m_id); e_sum = i_add_sum; e_err = 0; m_rsp = 1;
            end
`ifdef SERIAL_ADD_ARB_TIMEOUT_EN
            else if (m_age - 2 == TIMEOUT - 1) begin
                e_rv = 1; e_id = IW'(m_id); e_sum = 0; e_err = 1; m_rsp = 1;
            end
`endif
        end
        chk("gnt", o_gnt, e_gnt);
        chk("add_start", o_add_start, e_start);
        chk("add_a", o_add_a, e_a);
        chk("add_b", o_add_b, e_b);
        chk("rsp_valid", o_rsp_valid, e_rv);
        chk("rsp_id", o_rsp_id, e_id);
        chk("rsp_sum", o_rsp_sum, e_sum);
        chk("rsp_err", o_rsp_err, e_err);
        chk("busy", o_busy, m_busy);
        if (e_rv && !e_err)
            chk("sum_vs_operands", o_rsp_sum, 8'(cl_a[m_id] + cl_b[m_id]));

        // react: clients and engine
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin pend[i] = 0; outst[i] = 0; end
            eng_cnt = -1; i_add_done = 0; i_req = '0;
        end else begin
            if (o_gnt != '0) begin
                last_gnt_vec = o_gnt;
                for (int i = 0; i < NREQ; i++)
                    if (o_gnt[i]) begin
                        gnt_log.push_back(i); gnt_cyc[i] = cyc; pend[i] = 0; outst[i] = 1;
                    end
            end
            if (o_rsp_valid) begin
                rsp_count++; rsp_cyc = cyc; last_sum = o_rsp_sum; last_err = o_rsp_err;
                last_id = int'(o_rsp_id); outst[last_id] = 0;
                if (auto_rq[last_id]) begin
                    cl_a[last_id] = 8'($urandom); cl_b[last_id] = 8'($urandom); pend[last_id] = 1;
                end
            end
            i_add_done = 0;
            i_add_sum = 8'($urandom);
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    i_add_done = 1; i_add_sum = eng_sum; done_cyc = cyc; eng_cnt = -1;
                end
            end
            if (o_add_start) begin
                start_cyc = cyc; start_a = o_add_a; start_b = o_add_b;
                eng_sum = o_add_a + o_add_b;
                if (rand_mode) eng_dly = $urandom_range(1, 12);
                eng_cnt = eng_never ? -1 : eng_dly;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rand_mode && !pend[i] && !outst[i] && $urandom_range(0, 5) == 0) begin
                    cl_a[i] = 8'($urandom); cl_b[i] = 8'($urandom); pend[i] = 1;
                end
                if (!i_req[i] && (pend[i] || o_gnt[i])) req_cyc[i] = cyc;
                i_req[i] = pend[i] | o_gnt[i];
                i_req_a[i*WIDTH +: WIDTH] = cl_a[i];
                i_req_b[i*WIDTH +: WIDTH] = cl_b[i];
            end
        end
    end

    function automatic bit quiet();
        bit q = !o_busy;
        for (int i = 0; i < NREQ; i++) if (pend[i] || outst[i]) q = 0;
        return q;
    endfunction

    task automatic wait_quiet(input string nm, input int budget);
        int k = 0;
        do begin @(negedge clk); k++; end while (!quiet() && k < budget);
        if (!quiet()) begin
            n_tot++;
            $display("FAIL %s: still busy after %0d cycles", nm, budget);
        end
    endtask

    task automatic request(input int i, input logic [7:0] a, input logic [7:0] b);
        cl_a[i] = a; cl_b[i] = b; pend[i] = 1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gnt"}, o_gnt, 0);
        chk({nm, "_start"}, o_add_start, 0);
        chk({nm, "_a"}, o_add_a, 0);
        chk({nm, "_b"}, o_add_b, 0);
        chk({nm, "_rv"}, o_rsp_valid, 0);
        chk({nm, "_id"}, o_rsp_id, 0);
        chk({nm, "_sum"}, o_rsp_sum, 0);
        chk({nm, "_err"}, o_rsp_err, 0);
        chk({nm, "_busy"}, o_busy, 0);
    endtask

    initial begin
        int rc0, k;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; outst[i] = 0; auto_rq[i] = 0; cl_a[i] = 0; cl_b[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;

        // single request
        @(negedge clk);
        request(0, 8'h25, 8'h13);
        wait_quiet("single", 40);
        chk("single_gnt_vec", last_gnt_vec, 4'b0001);
        chk("single_latency", gnt_cyc[0] - req_cyc[0], 1);
        chk("single_start_cyc", start_cyc, gnt_cyc[0]);
        chk("single_add_a", start_a, 8'h25);
        chk("single_add_b", start_b, 8'h13);
        chk("single_rsp_id", last_id, 0);
        chk("single_rsp_sum", last_sum, 8'h38);
        chk("single_rsp_err", last_err, 0);
        chk("single_rsp_lat", rsp_cyc - done_cyc, 1);
        chk("single_rsp_count", rsp_count, 1);

        // reset pulse while WAITing on an engine that never answers
        eng_never = 1;
        @(negedge clk);
        request(2, 8'h11, 8'h22);
        repeat (6) @(negedge clk);
        rc0 = rsp_count;
        #2 rst = 1;
        #1 chk_all_zero("midrst");
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 0; eng_never = 0; eng_dly = 3;
        repeat (4) @(negedge clk);
        chk("midrst_no_rsp", rsp_count, rc0);

        // continuous requests from everyone, starting from ptr 0
        gnt_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            auto_rq[i] = 1; request(i, 8'($urandom), 8'($urandom));
        end
        k = 0;
        while (gnt_log.size() < 5 && k < 200) begin @(negedge clk); k++; end
        for (int i = 0; i < NREQ; i++) auto_rq[i] = 0;
        wait_quiet("cont", 200);
        if (gnt_log.size() < 5) begin
            n_tot++; $display("FAIL cont_count: got %0d grants want 5", gnt_log.size());
        end else begin
            chk("cont_g0", gnt_log[0], 0);
            chk("cont_g1", gnt_log[1], 1);
            chk("cont_g2", gnt_log[2], 2);
            chk("cont_g3", gnt_log[3], 3);
            chk("cont_g4", gnt_log[4], 0);
        end

        // rotation: after serving 1, both 1 and 3 request -> 3 first
        @(negedge clk);
        request(1, 8'h01, 8'h02);
        wait_quiet("rot_a", 40);
        gnt_log.delete();
        @(negedge clk);
        request(1, 8'h03, 8'h04);
        request(3, 8'h05, 8'h06);
        wait_quiet("rot_b", 60);
        chk("rot_size", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk("rot_first", gnt_log[0], 3);
            chk("rot_second", gnt_log[1], 1);
        end

        // modulo wrap
        @(negedge clk);
        request(2, 8'hFF, 8'h01);
        wait_quiet("wrap", 40);
        chk("wrap_id", last_id, 2);
        chk("wrap_sum", last_sum, 8'h00);
        chk("wrap_err", last_err, 0);

        // random traffic
        rand_mode = 1;
        repeat (400) @(negedge clk);
        rand_mode = 0;
        wait_quiet("random", 300);

        // engine never completes
        eng_never = 1;
        rc0 = rsp_count;
        @(negedge clk);
        request(0, 8'h44, 8'h55);
`ifdef SERIAL_ADD_ARB_TIMEOUT_EN
        k = 0;
        while (rsp_count == rc0 && k < 80) begin @(negedge clk); k++; end
        chk("to_rsp_count", rsp_count, rc0 + 1);
        chk("to_err", last_err, 1);
        chk("to_sum", last_sum, 0);
        chk("to_timing", rsp_cyc - gnt_cyc[0], 33);
        wait_quiet("to_end", 10);
`else
        repeat (80) @(negedge clk);
        chk("hang_busy", o_busy, 1);
        chk("hang_no_rsp", rsp_count, rc0);
        #2 rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0;
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/serial_add_arb.md
Name: serial_add_arb

Overview:
- Round-robin arbiter and sequencer that shares one bit-serial 8-bit adder engine among NREQ requesters.
- Captures the winning requester's operands and launches the engine with a single-cycle start.
- Waits for the engine's done, then returns the sum tagged with the requester id.
- Sits between client FSMs and the serial adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/sum width.
- TIMEOUT, 32, WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  in  NREQ*WIDTH  operand B; slice i belongs to requester i.
- gnt  out  NREQ  one-hot grant, high for exactly one cycle.
- add_start  out  1  engine start pulse.
- add_a  out  WIDTH  latched operand A to the engine.
- add_b  out  WIDTH  latched operand B to the engine.
- add_done  in  1  engine completion pulse.
- add_sum  in  WIDTH  engine result, valid with add_done.
- rsp_valid  out  1  response pulse.
- rsp_id  out  clog2(NREQ)  id of the requester being answered.
- rsp_sum  out  WIDTH  result.
- rsp_err  out  1  timeout flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, ptr 0, timeout count 0. All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req bit is high, pick the first set bit searching ptr, ptr+1, … with wrap from NREQ-1 to 0.
  - At that clock edge, latch id, add_a and add_b from the winner's slices, then go to LAUNCH.
  - If no req bit is high, stay in IDLE.
- LAUNCH (exactly 1 cycle): gnt[id]=1 and add_start=1, then go to WAIT. add_done is ignored in this cycle.
- WAIT:
  - On add_done, capture add_sum into rsp_sum, set rsp_err=0, go to RESP.
  - add_a and add_b stay stable throughout WAIT.
- RESP (1 cycle): rsp_valid=1 with rsp_id and rsp_sum; ptr <= (id==NREQ-1) ? 0 : id+1; return to IDLE.
- Latency: first req cycle N → gnt and add_start in cycle N+1 → rsp_valid one cycle after the add_done cycle.
- Requester handshake:
  - Holds req, req_a and req_b stable until it sees gnt.
  - Drops req the cycle after gnt.
  - Must not re-request before seeing its rsp_valid.
- Arithmetic: the sum is taken as-is from the engine, modulo 2^WIDTH. No carry-out is reported.
- A req change while the FSM is not in IDLE has no effect. Arbitration happens only in IDLE.
- Reset mid-operation: immediate return to IDLE, outputs 0, ptr 0. In-flight work is dropped and no response is issued.

Optional Feature:
- Macro: SERIAL_ADD_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter is cleared on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT-1 with no add_done, go to RESP with rsp_err=1 and rsp_sum=0.
  - If add_done and timeout occur in the same cycle, add_done wins and rsp_err=0.
- Undefined: no counter; WAIT holds until add_done; rsp_err is tied to 0.

Decomposition:
- Package serial_add_arb_pkg holds:
  - the state encoding (IDLE=0, LAUNCH=1, WAIT=2, RESP=3, 2 bits);
  - the default TIMEOUT constant.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, ptr.
  - Outputs: any, id.

Test Plan:
- Single request: req[0]=1, a=0x25, b=0x13, engine model done 9 cycles after start with sum 0x38 → gnt=0001 and add_start in the next cycle with add_a=0x25, add_b=0x13; one rsp_valid with id=0, sum=0x38, err=0.
- All four request continuously (re-requesting after each response) → grants in order 0,1,2,3,0; each gnt is one-hot and lasts 1 cycle.
- Priority rotation: after a grant to id1, req1 and req3 are both high → id3 granted before id1.
- Wrap: a=0xFF, b=0x01 → rsp_sum=0x00, rsp_err=0.
- Timeout with macro defined, TIMEOUT=32, engine never done → rsp_valid with err=1 and sum=0 exactly 32 WAIT cycles after entry. Without the macro, busy stays high indefinitely.
- Reset pulse during WAIT → all outputs 0 asynchronously; no rsp_valid; the next request after release is arbitrated from ptr 0.
